// File: rtl/loop_addr_gen_pkg.sv
// ----------------------------------------------------------------------------
// loop_addr_gen_pkg
// Shared definitions for the three-level loop address generator.
//   DEF_DATA_W / DEF_ADDR_W : default counter and address widths
//   state_t                 : pass FSM states (IDLE, RUN, DONE)
//   all_last()              : true when every loop level sits at its limit
// ----------------------------------------------------------------------------
package loop_addr_gen_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The final address of a pass is the one where all three levels wrap.
    function automatic logic all_last(input logic x_l, input logic y_l, input logic c_l);
        return x_l & y_l & c_l;
    endfunction

endpackage

// File: rtl/loop_addr_gen_if.sv
// ----------------------------------------------------------------------------
// loop_addr_gen_if
// Valid/ready address stream produced by loop_addr_gen.
//   addr_valid : addr (and the last flags) hold a valid address
//   addr_ready : consumer accepts the address when high with addr_valid
//   addr       : current address
//   x_last/y_last/c_last : matching loop counter is at its limit
// Modports: master (generator side), slave (consumer side).
// ----------------------------------------------------------------------------
interface loop_addr_gen_if
    import loop_addr_gen_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              addr_valid;
    logic              addr_ready;
    logic [ADDR_W-1:0] addr;
    logic              x_last;
    logic              y_last;
    logic              c_last;

    modport master (
        output addr_valid, addr, x_last, y_last, c_last,
        input  addr_ready
    );

    modport slave (
        input  addr_valid, addr, x_last, y_last, c_last,
        output addr_ready
    );
endinterface

// File: rtl/loop_addr_gen_nest_cnt.sv
// ----------------------------------------------------------------------------
// nest_cnt
// One level of a nested loop: counts 0..lim on each enabled cycle, then wraps.
//   clk, rst : clock, asynchronous active-low reset
//   en       : advance the counter this cycle
//   lim      : inclusive limit
//   cnt      : current count
//   last     : cnt equals lim (combinational, used to build the carry chain)
// ----------------------------------------------------------------------------
module nest_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] lim,
    output logic [W-1:0] cnt,
    output logic         last
);
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_r;

    // Wrap counter: advance when enabled, return to zero after the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {W{1'b0}};
        end else if (en) begin
            cnt_r <= (cnt_r == lim) ? {W{1'b0}} : (cnt_r + ONE);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt  = cnt_r;
    assign last = (cnt_r == lim);

endmodule

// File: rtl/loop_addr_gen.sv
// ----------------------------------------------------------------------------
// loop_addr_gen
// Walks a 3-level loop (x fastest, c slowest) and emits
//   addr = base + c*ch_stride + y*row_stride + x   (mod 2^ADDR_W)
// on a valid/ready stream. The address is built incrementally from a channel
// base and a row base accumulator, so no multipliers are needed.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   start                    : begin a pass (honoured only in IDLE)
//   x_lim, y_lim, c_lim      : inclusive loop limits
//   base, row_stride, ch_stride : address setup, latched on start
//   busy                     : high in RUN and DONE
//   done                     : one-cycle pulse after the final address
//   bus                      : address stream (master modport)
// ----------------------------------------------------------------------------
module loop_addr_gen
    import loop_addr_gen_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] x_lim,
    input  logic [DATA_W-1:0] y_lim,
    input  logic [DATA_W-1:0] c_lim,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] row_stride,
    input  logic [ADDR_W-1:0] ch_stride,
    output logic              busy,
    output logic              done,
    loop_addr_gen_if.master   bus
);
    localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    logic              busy_r, done_r, valid_r;
    logic [ADDR_W-1:0] addr_r, row_base_r, ch_base_r;
    logic [ADDR_W-1:0] row_stride_r, ch_stride_r;
    logic [DATA_W-1:0] x_lim_r, y_lim_r, c_lim_r;

    logic              xfer_s, x_last_s, y_last_s, c_last_s, run_s;
    logic [DATA_W-1:0] x_cnt_s, y_cnt_s, c_cnt_s;

    assign xfer_s = valid_r & bus.addr_ready;
    assign run_s  = (state_r == ST_RUN);

    // Carry chain: each level advances only when all faster levels wrap.
    nest_cnt #(.W(DATA_W)) u_x (
        .clk(clk), .rst(rst), .en(xfer_s),
        .lim(x_lim_r), .cnt(x_cnt_s), .last(x_last_s)
    );
    nest_cnt #(.W(DATA_W)) u_y (
        .clk(clk), .rst(rst), .en(xfer_s & x_last_s),
        .lim(y_lim_r), .cnt(y_cnt_s), .last(y_last_s)
    );
    nest_cnt #(.W(DATA_W)) u_c (
        .clk(clk), .rst(rst), .en(xfer_s & x_last_s & y_last_s),
        .lim(c_lim_r), .cnt(c_cnt_s), .last(c_last_s)
    );

    // Pass FSM plus address accumulators; every output here is a register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            valid_r      <= 1'b0;
            addr_r       <= {ADDR_W{1'b0}};
            row_base_r   <= {ADDR_W{1'b0}};
            ch_base_r    <= {ADDR_W{1'b0}};
            row_stride_r <= {ADDR_W{1'b0}};
            ch_stride_r  <= {ADDR_W{1'b0}};
            x_lim_r      <= {DATA_W{1'b0}};
            y_lim_r      <= {DATA_W{1'b0}};
            c_lim_r      <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        x_lim_r      <= x_lim;
                        y_lim_r      <= y_lim;
                        c_lim_r      <= c_lim;
                        row_stride_r <= row_stride;
                        ch_stride_r  <= ch_stride;
                        addr_r       <= base;
                        row_base_r   <= base;
                        ch_base_r    <= base;
                        valid_r      <= 1'b1;
                        busy_r       <= 1'b1;
                        state_r      <= ST_RUN;
                    end else begin
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (xfer_s) begin
                        if (all_last(x_last_s, y_last_s, c_last_s)) begin
                            valid_r <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else if (x_last_s && y_last_s) begin
                            // New channel: both row base and address restart there.
                            ch_base_r  <= ch_base_r + ch_stride_r;
                            row_base_r <= ch_base_r + ch_stride_r;
                            addr_r     <= ch_base_r + ch_stride_r;
                        end else if (x_last_s) begin
                            row_base_r <= row_base_r + row_stride_r;
                            addr_r     <= row_base_r + row_stride_r;
                        end else begin
                            addr_r <= addr_r + ONE_A;
                        end
                    end else begin
                        addr_r <= addr_r;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign bus.addr_valid = valid_r;
    assign bus.addr       = addr_r;
    // Last flags come straight from counter registers, qualified by RUN.
    assign bus.x_last     = run_s & x_last_s;
    assign bus.y_last     = run_s & y_last_s;
    assign bus.c_last     = run_s & c_last_s;

endmodule

// File: tb/tb_loop_addr_gen.sv
// ----------------------------------------------------------------------------
// tb_loop_addr_gen
// Directed bench for loop_addr_gen with hand-computed address sequences.
// ----------------------------------------------------------------------------
module tb_loop_addr_gen;
    import loop_addr_gen_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  x_lim, y_lim, c_lim;
    logic [15:0] base, row_stride, ch_stride;
    logic        busy, done;

    int n_cmp;
    int n_err;

    loop_addr_gen_if #(.ADDR_W(16)) bus_if ();

    loop_addr_gen #(.DATA_W(8), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .x_lim(x_lim), .y_lim(y_lim), .c_lim(c_lim),
        .base(base), .row_stride(row_stride), .ch_stride(ch_stride),
        .busy(busy), .done(done), .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] flags();
        return {bus_if.x_last, bus_if.y_last, bus_if.c_last};
    endfunction

    // Issue a one-cycle start, then scramble the setup inputs to prove they were latched.
    task automatic start_pass(input logic [15:0] b, input logic [7:0] xl, input logic [7:0] yl,
                              input logic [7:0] cl, input logic [15:0] rs, input logic [15:0] cs);
        base = b; x_lim = xl; y_lim = yl; c_lim = cl; row_stride = rs; ch_stride = cs;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        base = 16'hDEAD; x_lim = 8'd7; y_lim = 8'd7; c_lim = 8'd7;
        row_stride = 16'h0777; ch_stride = 16'h0999;
    endtask

    // Reference pass: base 0x100, x_lim 2, y_lim 1, c_lim 0, row_stride 0x10, ready held high.
    // poke = 1 pulses start mid-pass and during DONE; both must be ignored.
    task automatic run_ref_pass(input string tg, input bit poke);
        logic [15:0] exp_a [6];
        logic [2:0]  exp_f [6];
        exp_a = '{16'h0100, 16'h0101, 16'h0102, 16'h0110, 16'h0111, 16'h0112};
        exp_f = '{3'b001, 3'b001, 3'b101, 3'b011, 3'b011, 3'b111};
        start_pass(16'h0100, 8'd2, 8'd1, 8'd0, 16'h0010, 16'h0000);
        for (int i = 0; i < 6; i++) begin
            if (poke && i == 2) begin
                start = 1'b1;
                base  = 16'h0900;
            end else begin
                start = 1'b0;
            end
            check_val({tg, "_valid"}, {31'd0, bus_if.addr_valid}, 32'd1);
            check_val({tg, "_addr"}, {16'd0, bus_if.addr}, {16'd0, exp_a[i]});
            check_val({tg, "_last"}, {29'd0, flags()}, {29'd0, exp_f[i]});
            check_val({tg, "_nodone"}, {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        start = poke ? 1'b1 : 1'b0;
        check_val({tg, "_done"}, {31'd0, done}, 32'd1);
        check_val({tg, "_done_valid"}, {31'd0, bus_if.addr_valid}, 32'd0);
        check_val({tg, "_done_busy"}, {31'd0, busy}, 32'd1);
        check_val({tg, "_done_last"}, {29'd0, flags()}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        check_val({tg, "_idle_done"}, {31'd0, done}, 32'd0);
        check_val({tg, "_idle_busy"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        check_val({tg, "_idle_valid"}, {31'd0, bus_if.addr_valid}, 32'd0);
    endtask

    initial begin
        logic [15:0] exp_c [7];
        int          n_done;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0; start = 1'b0; bus_if.addr_ready = 1'b1;
        x_lim = 8'd0; y_lim = 8'd0; c_lim = 8'd0;
        base = 16'd0; row_stride = 16'd0; ch_stride = 16'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_valid", {31'd0, bus_if.addr_valid}, 32'd0);
        check_val("rst_addr", {16'd0, bus_if.addr}, 32'd0);
        check_val("rst_last", {29'd0, flags()}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Basic 3x2x1 walk
        run_ref_pass("ref", 1'b0);

        // All limits zero: one address, every last flag set, busy for two cycles
        start_pass(16'h0055, 8'd0, 8'd0, 8'd0, 16'h0010, 16'h0040);
        check_val("one_addr", {16'd0, bus_if.addr}, 32'h55);
        check_val("one_last", {29'd0, flags()}, 32'd7);
        check_val("one_busy1", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check_val("one_done", {31'd0, done}, 32'd1);
        check_val("one_busy2", {31'd0, busy}, 32'd1);
        check_val("one_valid", {31'd0, bus_if.addr_valid}, 32'd0);
        @(negedge clk);
        check_val("one_busy3", {31'd0, busy}, 32'd0);
        check_val("one_done2", {31'd0, done}, 32'd0);

        // Channel step with 16-bit wrap and ready toggling 1,0,1,0...
        exp_c = '{16'hFFF0, 16'hFFF1, 16'hFFF1, 16'h0030, 16'h0030, 16'h0031, 16'h0031};
        start_pass(16'hFFF0, 8'd1, 8'd0, 8'd1, 16'h0010, 16'h0040);
        for (int i = 0; i < 7; i++) begin
            bus_if.addr_ready = (i % 2 == 0) ? 1'b1 : 1'b0;
            check_val("wrap_valid", {31'd0, bus_if.addr_valid}, 32'd1);
            check_val("wrap_addr", {16'd0, bus_if.addr}, {16'd0, exp_c[i]});
            if (i == 3) check_val("wrap_last_c", {29'd0, flags()}, 32'd3);
            if (i == 5) check_val("wrap_last_f", {29'd0, flags()}, 32'd7);
            @(negedge clk);
        end
        bus_if.addr_ready = 1'b1;
        check_val("wrap_done", {31'd0, done}, 32'd1);
        @(negedge clk);

        // Start pulses during RUN and DONE must not disturb or restart the pass
        run_ref_pass("poke", 1'b1);

        // Reset in the middle of the third transfer, then a fresh pass
        start_pass(16'h0100, 8'd2, 8'd1, 8'd0, 16'h0010, 16'h0000);
        check_val("mid_addr0", {16'd0, bus_if.addr}, 32'h100);
        @(negedge clk);
        check_val("mid_addr1", {16'd0, bus_if.addr}, 32'h101);
        @(negedge clk);
        check_val("mid_addr2", {16'd0, bus_if.addr}, 32'h102);
        rst = 1'b0;
        #1;
        check_val("mid_rst_valid", {31'd0, bus_if.addr_valid}, 32'd0);
        check_val("mid_rst_addr", {16'd0, bus_if.addr}, 32'd0);
        check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_val("mid_rst_last", {29'd0, flags()}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        n_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check_val("mid_no_done", n_done, 32'd0);
        run_ref_pass("after_rst", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/loop_addr_gen.md
LOOP_ADDR_GEN -- requirements
Module: loop_addr_gen

Interface
REQ-001 Parameter DATA_W, default 8, width of each loop limit and counter.
REQ-002 Parameter ADDR_W, default 16, width of base, strides and address.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a pass; honoured only in IDLE.
REQ-006 x_lim, y_lim, c_lim  input  DATA_W each  inclusive limits; each counter runs 0..lim.
REQ-007 base  input  ADDR_W  first address of the pass.
REQ-008 row_stride, ch_stride  input  ADDR_W each  address step per y and per c increment.
REQ-009 busy  output  1  high in RUN and DONE.
REQ-010 done  output  1  one-cycle pulse after the final address is accepted.
REQ-011 addr_valid  output  1  addr holds a valid address.
REQ-012 addr_ready  input  1  consumer accepts addr when high together with addr_valid.
REQ-013 addr  output  ADDR_W  current address.
REQ-014 x_last, y_last, c_last  output  1 each  current x/y/c counter equals its limit; aligned with addr.

Function
REQ-015 The block SHALL have a three-state FSM: IDLE, RUN, DONE.
REQ-016 IDLE->RUN on start; limits, base and strides SHALL be latched on that edge and input changes ignored until the next IDLE.
REQ-017 addr_valid SHALL rise the cycle after start, with addr = base and x, y, c = 0.
REQ-018 Handshake: a transfer occurs when addr_valid and addr_ready are both high; addr and last flags SHALL stay stable while addr_valid is high and addr_ready is low.
REQ-019 On transfer, x increments; at x==x_lim, x wraps to 0 and y increments; at y==y_lim, y wraps to 0 and c increments (x fastest, c slowest).
REQ-020 Address SHALL equal base + c*ch_stride + y*row_stride + x, modulo 2^ADDR_W, computed incrementally with row and channel base accumulators (no multipliers).
REQ-021 Transfer with x_last, y_last and c_last all high SHALL move RUN->DONE and drop addr_valid in the next cycle.
REQ-022 DONE SHALL last exactly one cycle, assert done, then go to IDLE.
REQ-023 start in RUN or DONE SHALL be ignored; start in the same cycle as the return to IDLE is not honoured.
REQ-024 All limits equal to 0 SHALL produce exactly one address, with all three last flags high.
REQ-025 Total transfers per pass SHALL be (x_lim+1)*(y_lim+1)*(c_lim+1).
REQ-026 Outside RUN, last flags SHALL be 0.

Reset
REQ-027 On rst low, the block SHALL asynchronously enter IDLE; busy, done, addr_valid, last flags and addr SHALL be 0, and counters and accumulators cleared.
REQ-028 Reset mid-pass SHALL abandon the pass with no done pulse; after rst rises, the first start begins a fresh pass.

Structure
REQ-029 FSM state enum and default DATA_W/ADDR_W constants SHALL live in the shared common package.
REQ-030 One sub-module, nest_cnt, SHALL implement a single-level wrap counter with enable, limit, cnt and comb last output, using asynchronous active-low reset; it is instantiated three times, chained through carry.

Verification
REQ-031 base=0x100, x_lim=2, y_lim=1, c_lim=0, row_stride=0x10, ready always 1 -> addr 0x100,0x101,0x102,0x110,0x111,0x112 on consecutive cycles; done one cycle after 0x112.
REQ-032 All limits 0, base=0x55 -> single addr 0x55 with all last flags high; done follows; busy high for 2 cycles.
REQ-033 x_lim=1, y_lim=0, c_lim=1, ch_stride=0x40, base=0xFFF0, ADDR_W=16, ready toggling 1010 -> addr 0xFFF0,0xFFF1,0x0030,0x0031; each held while ready low.
REQ-034 start pulsed in RUN with different base -> running pass unaffected; exactly one done.
REQ-035 rst low during third transfer of REQ-031 -> outputs 0 immediately, no done; new start then reproduces the full REQ-031 sequence.
